// File: rtl/lot_pkg.sv
// Shared types and default constants for the Lot round sequencer.
package lot_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_P1     = 3'd1,
        S_P1_END = 3'd2,
        S_P2     = 3'd3,
        S_P2_END = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    localparam logic [1:0] TURN_IDLE   = 2'b00;
    localparam logic [1:0] TURN_P1     = 2'b01;
    localparam logic [1:0] TURN_P2     = 2'b10;
    localparam logic [1:0] TURN_RESULT = 2'b11;

    localparam int DEF_MAX_NUMS    = 4;
    localparam int DEF_MAX_VAL     = 9;
    localparam int DEF_TIMEOUT_CYC = 50_000_000;

    // The *_END states still belong to the player whose turn is closing.
    function automatic logic [1:0] turn_of(input state_t s);
        case (s)
            S_P1, S_P1_END: turn_of = TURN_P1;
            S_P2, S_P2_END: turn_of = TURN_P2;
            S_RESULT:       turn_of = TURN_RESULT;
            default:        turn_of = TURN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic s1_reg;
    logic s2_reg;
    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg    <= 1'b0;
            s2_reg    <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            s1_reg    <= btn;
            s2_reg    <= s1_reg;
            prev_reg  <= s2_reg;
            pulse_reg <= s2_reg & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/lot_round_ctrl.sv
// Round sequencer: conditions board inputs, alternates player turns and
// issues single-cycle insert / end-of-turn / end-of-game strobes to Lot.
module lot_round_ctrl
    import lot_pkg::*;
#(
    parameter int MAX_NUMS    = DEF_MAX_NUMS,
    parameter int MAX_VAL     = DEF_MAX_VAL,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_insere,
    input  logic       btn_fim,
    input  logic       btn_fim_jogo,
    input  logic [3:0] num_sw,
    output logic [3:0] lot_num,
    output logic       lot_insere,
    output logic       lot_fim,
    output logic       lot_fim_jogo,
    output logic [1:0] turn,
    output logic [3:0] count,
    output logic       err,
    output logic       timed_out
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    MAX_N    = 4'(MAX_NUMS);
    localparam logic [3:0]    MAX_V    = 4'(MAX_VAL);

    logic [2:0] btn_raw;
    logic [2:0] btn_edge;
    logic       ins_e, fim_e, fj_e;

    assign btn_raw = {btn_fim_jogo, btn_fim, btn_insere};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_sync_edge u_btn (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .pulse (btn_edge[gi])
            );
        end
    endgenerate

    assign ins_e = btn_edge[0];
    assign fim_e = btn_edge[1];
    assign fj_e  = btn_edge[2];

    logic [3:0] num_s1_reg, num_sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_s1_reg   <= '0;
            num_sync_reg <= '0;
        end else begin
            num_s1_reg   <= num_sw;
            num_sync_reg <= num_s1_reg;
        end
    end

    state_t     state_reg, state_next;
    logic [3:0] count_reg, count_next, count_inc;
    logic [TW-1:0] tmo_reg, tmo_next;
    logic       pend_reg, pend_next;
    logic       timed_out_reg, timed_out_next;
    logic [3:0] num_reg, num_next;
    logic       ins_reg, ins_next;
    logic       fim_reg, fim_next;
    logic       fj_reg, fj_next;
    logic       err_reg, err_next;
    logic       end_turn;

    assign count_inc = count_reg + 4'd1;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        tmo_next       = tmo_reg;
        pend_next      = pend_reg;
        timed_out_next = timed_out_reg;
        num_next       = '0;
        ins_next       = 1'b0;
        fim_next       = 1'b0;
        fj_next        = 1'b0;
        err_next       = 1'b0;
        end_turn       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (ins_e) begin
                    state_next     = S_P1;
                    count_next     = '0;
                    tmo_next       = '0;
                    pend_next      = 1'b0;
                    timed_out_next = 1'b0;
                end
            end
            S_P1, S_P2: begin
                if (fj_e) begin
                    fj_next    = 1'b1;
                    state_next = S_IDLE;
                    count_next = '0;
                    tmo_next   = '0;
                    pend_next  = 1'b0;
                end else if (pend_reg) begin
                    // Deferred close keeps lot_fim one cycle behind lot_insere.
                    end_turn = 1'b1;
                end else if (ins_e || fim_e) begin
                    tmo_next = '0;
                    if (ins_e) begin
                        if (num_sync_reg <= MAX_V) begin
                            ins_next   = 1'b1;
                            num_next   = num_sync_reg;
                            count_next = count_inc;
                            if (count_inc == MAX_N)
                                pend_next = 1'b1;
                        end else begin
                            err_next = 1'b1;
                        end
                        if (fim_e)
                            pend_next = 1'b1;
                    end else begin
                        end_turn = 1'b1;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    end_turn       = 1'b1;
                    timed_out_next = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TW'(1);
                end

                if (end_turn) begin
                    state_next = (state_reg == S_P1) ? S_P1_END : S_P2_END;
                    fim_next   = 1'b1;
                    count_next = '0;
                    pend_next  = 1'b0;
                    tmo_next   = '0;
                end
            end
            S_P1_END: begin
                state_next     = S_P2;
                tmo_next       = '0;
                timed_out_next = 1'b0;
            end
            S_P2_END: begin
                state_next = S_RESULT;
            end
            S_RESULT: begin
                if (fj_e) begin
                    fj_next    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
                tmo_next   = '0;
                pend_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            count_reg     <= '0;
            tmo_reg       <= '0;
            pend_reg      <= 1'b0;
            timed_out_reg <= 1'b0;
            num_reg       <= '0;
            ins_reg       <= 1'b0;
            fim_reg       <= 1'b0;
            fj_reg        <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            tmo_reg       <= tmo_next;
            pend_reg      <= pend_next;
            timed_out_reg <= timed_out_next;
            num_reg       <= num_next;
            ins_reg       <= ins_next;
            fim_reg       <= fim_next;
            fj_reg        <= fj_next;
            err_reg       <= err_next;
        end
    end

    assign lot_num      = num_reg;
    assign lot_insere   = ins_reg;
    assign lot_fim      = fim_reg;
    assign lot_fim_jogo = fj_reg;
    assign err          = err_reg;
    assign count        = count_reg;
    assign timed_out    = timed_out_reg;
    assign turn         = turn_of(state_reg);

endmodule

// File: tb/tb_lot_round_ctrl.sv
// Scoreboard bench for lot_round_ctrl: stimulus queues expected strobe events,
// a monitor pops and compares them whenever a strobe or err appears.
module tb_lot_round_ctrl;

    localparam int K_INS = 0;
    localparam int K_FIM = 1;
    localparam int K_FJ  = 2;
    localparam int K_ERR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_insere = 1'b0, btn_fim = 1'b0, btn_fim_jogo = 1'b0;
    logic [3:0] num_sw = '0;
    logic [3:0] lot_num;
    logic       lot_insere, lot_fim, lot_fim_jogo;
    logic [1:0] turn;
    logic [3:0] count;
    logic       err;
    logic       timed_out;

    typedef struct {
        int         kind;
        logic [3:0] num;
        logic [1:0] turn;
        logic [3:0] cnt;
        logic       tmo;
        int         gap;   // cycles since previous event; 0 = don't care
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ev_cyc = -1000;

    lot_round_ctrl #(.MAX_NUMS(4), .MAX_VAL(9), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .btn_insere(btn_insere), .btn_fim(btn_fim), .btn_fim_jogo(btn_fim_jogo),
        .num_sw(num_sw), .lot_num(lot_num), .lot_insere(lot_insere),
        .lot_fim(lot_fim), .lot_fim_jogo(lot_fim_jogo), .turn(turn),
        .count(count), .err(err), .timed_out(timed_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [3:0] num, input logic [1:0] tr,
                             input logic [3:0] cnt, input logic tmo, input int gap);
        exp_t e;
        e.kind = kind; e.num = num; e.turn = tr; e.cnt = cnt; e.tmo = tmo; e.gap = gap;
        q.push_back(e);
    endtask

    // b = {fim_jogo, fim, insere}
    task automatic press(input logic [2:0] b, input int hold);
        @(negedge clk);
        {btn_fim_jogo, btn_fim, btn_insere} = b;
        repeat (hold) @(negedge clk);
        {btn_fim_jogo, btn_fim, btn_insere} = 3'b000;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, q.size(), 0);
    endtask

    // Monitor: one line per observed transaction.
    always @(negedge clk) begin
        if (!reset && (lot_insere || lot_fim || lot_fim_jogo || err)) begin
            int   kind;
            exp_t e;
            kind = lot_insere ? K_INS : lot_fim ? K_FIM : lot_fim_jogo ? K_FJ : K_ERR;
            $display("event kind=%0d num=%0d turn=%0d count=%0d timed_out=%0d cyc=%0d",
                     kind, lot_num, turn, count, timed_out, cyc);
            chk("strobe_exclusive", ($countones({lot_insere, lot_fim, lot_fim_jogo, err}) == 1), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
            end else begin
                e = q.pop_front();
                chk("ev_kind", kind, e.kind);
                if (e.kind == K_INS) chk("ev_lot_num", lot_num, e.num);
                chk("ev_turn", turn, e.turn);
                chk("ev_count", count, e.cnt);
                chk("ev_timed_out", timed_out, e.tmo);
                if (e.gap != 0) chk("ev_gap", cyc - last_ev_cyc, e.gap);
            end
            last_ev_cyc = cyc;
        end
    end

    initial begin
        int press_cyc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_turn", turn, 0);
        chk("rst_count", count, 0);
        chk("rst_strobes", {lot_insere, lot_fim, lot_fim_jogo, err, timed_out}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Start: insere in IDLE inserts nothing
        press(3'b001, 1);
        chk("start_turn", turn, 1);
        chk("start_count", count, 0);

        // First insert, long hold, 4-cycle latency
        num_sw = 4'd5;
        expect_ev(K_INS, 4'd5, 2'b01, 4'd1, 1'b0, 0);
        @(negedge clk);
        press_cyc = cyc;
        btn_insere = 1'b1;
        repeat (10) @(negedge clk);
        btn_insere = 1'b0;
        repeat (4) @(negedge clk);
        drain("insert1");
        chk("insert1_latency", last_ev_cyc - press_cyc, 4);
        chk("insert1_count", count, 1);

        // Abort with fim_jogo in P1
        expect_ev(K_FJ, 4'd0, 2'b00, 4'd0, 1'b0, 0);
        press(3'b100, 1);
        drain("abort_fj");
        chk("abort_fj_turn", turn, 0);

        // Entry limit: four inserts, then lot_fim the next cycle
        press(3'b001, 1);
        for (int i = 1; i <= 4; i++) begin
            num_sw = 4'(i);
            expect_ev(K_INS, 4'(i), 2'b01, 4'(i), 1'b0, 0);
            if (i == 4) expect_ev(K_FIM, 4'd0, 2'b01, 4'd0, 1'b0, 1);
            press(3'b001, 1);
        end
        drain("limit");
        chk("limit_turn", turn, 2);
        chk("limit_count", count, 0);

        // Rejected number in P2
        num_sw = 4'd12;
        expect_ev(K_ERR, 4'd0, 2'b10, 4'd0, 1'b0, 0);
        press(3'b001, 1);
        drain("reject");
        chk("reject_count", count, 0);

        // Close P2 by fim, leave RESULT by fim_jogo
        expect_ev(K_FIM, 4'd0, 2'b10, 4'd0, 1'b0, 0);
        press(3'b010, 1);
        drain("p2_fim");
        chk("result_turn", turn, 3);
        expect_ev(K_FJ, 4'd0, 2'b00, 4'd0, 1'b0, 0);
        press(3'b100, 1);
        drain("result_fj");

        // Simultaneous insere + fim in P1
        press(3'b001, 1);
        num_sw = 4'd7;
        expect_ev(K_INS, 4'd7, 2'b01, 4'd1, 1'b0, 0);
        expect_ev(K_FIM, 4'd0, 2'b01, 4'd0, 1'b0, 1);
        press(3'b011, 1);
        drain("simul");
        chk("simul_turn", turn, 2);

        // Timeout in P2, then fim_jogo from RESULT
        expect_ev(K_FIM, 4'd0, 2'b10, 4'd0, 1'b1, 0);
        drain("timeout");
        @(negedge clk);
        chk("timeout_turn", turn, 3);
        chk("timeout_flag", timed_out, 1);
        expect_ev(K_FJ, 4'd0, 2'b00, 4'd0, 1'b1, 0);
        press(3'b100, 1);
        drain("timeout_fj");
        chk("timeout_fj_turn", turn, 0);

        // Reset mid-P1 with count=2
        press(3'b001, 1);
        chk("p1_again_timed_out", timed_out, 0);
        for (int i = 1; i <= 2; i++) begin
            num_sw = 4'(i);
            expect_ev(K_INS, 4'(i), 2'b01, 4'(i), 1'b0, 0);
            press(3'b001, 1);
        end
        drain("pre_reset");
        chk("pre_reset_count", count, 2);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_turn", turn, 0);
        chk("midrst_count", count, 0);
        chk("midrst_outs", {lot_num, lot_insere, lot_fim, lot_fim_jogo, err, timed_out}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_turn", turn, 0);
        chk("post_rst_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lot_round_ctrl.md
Name: lot_round_ctrl

Overview:
- Round sequencer placed between the raw board inputs (switches, push-buttons) and the Lot datapath.
- Synchronises and edge-detects the buttons, and validates the entered number.
- Alternates turns between player 1 and player 2, and enforces a per-player entry limit and an inactivity timeout.
- Issues single-cycle insere/fim/fim_jogo pulses to Lot, plus turn/status signals for Display.

Parameters:
- MAX_NUMS, 4: numbers each player may insert per turn (1..15).
- MAX_VAL, 9: highest legal value of num_sw; larger values are rejected.
- TIMEOUT_CYC, 50_000_000: idle cycles in a player turn before the turn is force-ended.

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  asynchronous, active-high reset
- btn_insere  in  1  raw insert button, active high, asynchronous to clk
- btn_fim  in  1  raw end-of-turn button, active high
- btn_fim_jogo  in  1  raw end-of-game button, active high
- num_sw  in  4  raw number switches
- lot_num  out  4  registered number presented to Lot; valid while lot_insere=1
- lot_insere  out  1  one-cycle insert strobe to Lot
- lot_fim  out  1  one-cycle end-of-turn strobe to Lot
- lot_fim_jogo  out  1  one-cycle end-of-game strobe to Lot
- turn  out  2  00 idle, 01 player1, 10 player2, 11 result
- count  out  4  numbers accepted in the current turn
- err  out  1  one-cycle pulse when an out-of-range number is rejected
- timed_out  out  1  sticky flag: last turn ended by timeout; cleared when the next turn starts

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0, state is IDLE, and the synchronisers, counters and pending flag are cleared.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then a registered rising-edge detector.
  - num_sw passes through a 2-flop synchroniser.
  - Latency: the edge pulse is internal cycle 3 after the first clk edge that samples the button high. The resulting Lot strobe appears on the following cycle (cycle 4).
  - A held button produces exactly one edge.
- States: IDLE, P1, P1_END, P2, P2_END, RESULT.
- IDLE:
  - turn=00.
  - An insere edge goes to P1. This is a start action only; no number is inserted.
  - Other edges are ignored.
- P1 / P2 (turn=01 / 10):
  - Insere edge with num ≤ MAX_VAL: next cycle lot_insere=1, lot_num=num, count+1, timeout counter cleared.
  - Insere edge with num > MAX_VAL: err=1 for one cycle; count unchanged; timeout counter still cleared.
  - When the accepted insert makes count reach MAX_NUMS, go to Px_END.
  - A fim edge goes to Px_END. This is allowed with count=0.
  - If insere and fim edges occur in the same cycle, the insert is processed first and a pending-fim flag is set. Px_END is entered on the next cycle, so lot_insere and lot_fim never coincide.
  - Timeout counter increments every cycle with no edge. At TIMEOUT_CYC-1 it forces Px_END and sets timed_out.
  - A fim_jogo edge aborts the game: lot_fim_jogo pulses, go to IDLE, count=0.
- P1_END / P2_END:
  - lot_fim=1 for exactly one cycle, count cleared.
  - P1_END goes to P2; P2_END goes to RESULT.
  - Button edges arriving in these states are dropped.
- RESULT (turn=11):
  - Only a fim_jogo edge is honoured; it pulses lot_fim_jogo and goes to IDLE.
  - No timeout in this state.
- Strobes are registered, one cycle long, and mutually exclusive in every cycle.
- count never exceeds MAX_NUMS. The timeout counter saturates and never wraps.
- Reset asserted mid-turn: immediate return to IDLE with no strobe emitted.

Decomposition:
- Package lot_pkg holds:
  - the state enumeration (IDLE..RESULT, 3-bit encoding);
  - the turn codes;
  - the default MAX_NUMS, MAX_VAL and TIMEOUT_CYC constants.
- Sub-module btn_sync_edge: 2-flop synchroniser plus rising-edge pulse, async active-high reset. Instantiated three times.
- The FSM, counters and pending-fim logic stay in lot_round_ctrl.

Test Plan (MAX_NUMS=4, MAX_VAL=9, TIMEOUT_CYC=16):
- Start and insert:
  - Stimulus: reset, insere press in IDLE, then num_sw=5 and a second insere press held 10 cycles.
  - Response: turn=01; exactly one lot_insere with lot_num=5, 4 cycles after the press; count=1.
- Entry limit:
  - Stimulus: four inserts of 1, 2, 3, 4 in P1.
  - Response: lot_fim pulses the cycle after the 4th insert; turn=10; count=0.
- Rejected number:
  - Stimulus: num_sw=12 with an insere press in P2.
  - Response: err pulses once; no lot_insere; count unchanged.
- Simultaneous edges:
  - Stimulus: insere and fim edges in the same cycle in P1 with num_sw=7.
  - Response: lot_insere (lot_num=7), then lot_fim on the next cycle; turn=10.
- Timeout:
  - Stimulus: no input in P2 for 16 cycles.
  - Response: lot_fim pulses; timed_out=1; turn=11; a later fim_jogo press pulses lot_fim_jogo and returns turn=00.
- Aborts:
  - Stimulus: reset asserted mid-P1 with count=2.
  - Response: all outputs 0 immediately; no strobes.
  - Stimulus: fim_jogo press in P1.
  - Response: lot_fim_jogo pulses; turn=00.
